// File: rtl/bip_pkg.sv
// rtl/bip_pkg.sv - shared BIP opcodes, accumulator select codes, FSM states and width defaults
package bip_pkg;

   localparam int NB_OPCODE_DEF  = 5;
   localparam int NB_OPERAND_DEF = 11;
   localparam int NB_ADDR_DEF    = 11;
   localparam int NB_SEL_A_DEF   = 2;
   localparam int RAM_RD_LAT_DEF = 1;
   localparam int NB_COUNT_DEF   = 16;

   // wide enough for the largest supported RAM read latency (7)
   localparam int NB_WAIT = 3;

   localparam int OP_HLT  = 0;
   localparam int OP_STO  = 1;
   localparam int OP_LD   = 2;
   localparam int OP_LDI  = 3;
   localparam int OP_ADD  = 4;
   localparam int OP_ADDI = 5;
   localparam int OP_SUB  = 6;
   localparam int OP_SUBI = 7;
   localparam int OP_JMP  = 8;

   localparam int SELA_RAM = 0;
   localparam int SELA_IMM = 1;
   localparam int SELA_ALU = 2;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_EXEC  = 3'd2,
      ST_WAIT  = 3'd3,
      ST_HALT  = 3'd4
   } state_t;

endpackage

// File: rtl/bip_opcode_decode.sv
// rtl/bip_opcode_decode.sv - combinational map from BIP opcode to datapath control set
module bip_opcode_decode
   import bip_pkg::*;
#(
   parameter int NB_OPCODE = NB_OPCODE_DEF,
   parameter int NB_SEL_A  = NB_SEL_A_DEF
)(
   input  logic [NB_OPCODE-1:0] opcode,
   output logic                 legal,
   output logic                 is_halt,
   output logic                 rd_ram,
   output logic                 wr_ram,
   output logic                 wr_acc,
   output logic [NB_SEL_A-1:0]  sel_a,
   output logic                 sel_b,
   output logic [NB_OPCODE-1:0] alu_op,
   output logic                 is_jump
);

   // Accumulator selects and ALU op stay zero for anything that does not write the accumulator
   always_comb begin
      legal   = 1'b1;
      is_halt = 1'b0;
      rd_ram  = 1'b0;
      wr_ram  = 1'b0;
      wr_acc  = 1'b0;
      sel_a   = '0;
      sel_b   = 1'b0;
      alu_op  = '0;
      is_jump = 1'b0;
      case (opcode)
         NB_OPCODE'(OP_HLT): is_halt = 1'b1;
         NB_OPCODE'(OP_STO): wr_ram  = 1'b1;
         NB_OPCODE'(OP_LD): begin
            rd_ram = 1'b1;
            wr_acc = 1'b1;
            sel_a  = NB_SEL_A'(SELA_RAM);
         end
         NB_OPCODE'(OP_LDI): begin
            wr_acc = 1'b1;
            sel_a  = NB_SEL_A'(SELA_IMM);
         end
         NB_OPCODE'(OP_ADD), NB_OPCODE'(OP_SUB): begin
            rd_ram = 1'b1;
            wr_acc = 1'b1;
            sel_a  = NB_SEL_A'(SELA_ALU);
            sel_b  = 1'b0;
            alu_op = opcode;
         end
         NB_OPCODE'(OP_ADDI), NB_OPCODE'(OP_SUBI): begin
            wr_acc = 1'b1;
            sel_a  = NB_SEL_A'(SELA_ALU);
            sel_b  = 1'b1;
            alu_op = opcode;
         end
         NB_OPCODE'(OP_JMP): is_jump = 1'b1;
         default:            legal   = 1'b0;
      endcase
   end

endmodule

// File: rtl/bip_control_unit.sv
// rtl/bip_control_unit.sv - BIP sequencer: PC, fetch, decode, RAM-read wait, halt trap, single step, retire count
module bip_control_unit
   import bip_pkg::*;
#(
   parameter int NB_OPCODE  = NB_OPCODE_DEF,
   parameter int NB_OPERAND = NB_OPERAND_DEF,
   parameter int NB_ADDR    = NB_ADDR_DEF,
   parameter int NB_SEL_A   = NB_SEL_A_DEF,
   parameter int RAM_RD_LAT = RAM_RD_LAT_DEF,
   parameter int NB_COUNT   = NB_COUNT_DEF
)(
   input  logic                            i_clock,
   input  logic                            i_reset,
   input  logic                            i_start,
   input  logic                            i_step,
   input  logic [NB_OPCODE+NB_OPERAND-1:0] i_instruction,
   output logic [NB_ADDR-1:0]              o_pc,
   output logic [NB_OPERAND-1:0]           o_operand,
   output logic                            o_wrPc,
   output logic [NB_SEL_A-1:0]             o_selA,
   output logic                            o_selB,
   output logic                            o_wrAcc,
   output logic [NB_OPCODE-1:0]            o_op,
   output logic                            o_wrRam,
   output logic                            o_rdRam,
   output logic                            o_halted,
   output logic                            o_illegal,
   output logic [NB_COUNT-1:0]             o_instr_count
);

   localparam int NB_INSTR = NB_OPCODE + NB_OPERAND;

   state_t                 state;
   logic [NB_INSTR-1:0]    ir;
   logic [NB_WAIT-1:0]     wait_cnt;
   logic [NB_COUNT-1:0]    count;

   logic [NB_INSTR-1:0]    cur_instr;
   logic [NB_OPCODE-1:0]   cur_opcode;
   logic [NB_OPERAND-1:0]  cur_operand;

   logic                   dec_legal;
   logic                   dec_halt;
   logic                   dec_rd_ram;
   logic                   dec_wr_ram;
   logic                   dec_wr_acc;
   logic [NB_SEL_A-1:0]    dec_sel_a;
   logic                   dec_sel_b;
   logic [NB_OPCODE-1:0]   dec_alu_op;
   logic                   dec_jump;

   logic                   exec_ok;
   logic                   rd_defer;
   logic                   wait_done;
   logic                   do_retire;
   logic [NB_ADDR-1:0]     pc_next;
   logic [NB_COUNT-1:0]    count_next;

   // Fresh memory data is decoded in EXEC; the latched IR drives decode while waiting on RAM
   assign cur_instr   = (state == ST_WAIT) ? ir : i_instruction;
   assign cur_opcode  = cur_instr[NB_INSTR-1 -: NB_OPCODE];
   assign cur_operand = cur_instr[NB_OPERAND-1:0];

   bip_opcode_decode #(
      .NB_OPCODE (NB_OPCODE),
      .NB_SEL_A  (NB_SEL_A)
   ) u_decode (
      .opcode    (cur_opcode),
      .legal     (dec_legal),
      .is_halt   (dec_halt),
      .rd_ram    (dec_rd_ram),
      .wr_ram    (dec_wr_ram),
      .wr_acc    (dec_wr_acc),
      .sel_a     (dec_sel_a),
      .sel_b     (dec_sel_b),
      .alu_op    (dec_alu_op),
      .is_jump   (dec_jump)
   );

   assign exec_ok    = (state == ST_EXEC) && dec_legal && !dec_halt;
   assign rd_defer   = dec_rd_ram && (RAM_RD_LAT != 0);
   assign wait_done  = (state == ST_WAIT) && (wait_cnt == NB_WAIT'(1));
   assign do_retire  = (exec_ok && !rd_defer) || wait_done;
   assign pc_next    = dec_jump ? cur_operand[NB_ADDR-1:0] : o_pc + NB_ADDR'(1);
   assign count_next = (&count) ? count : count + NB_COUNT'(1);

   assign o_instr_count = count;

   // Sequencer: state, IR, wait counter, PC, retire counter and every registered control output
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         state     <= ST_IDLE;
         ir        <= '0;
         wait_cnt  <= '0;
         count     <= '0;
         o_pc      <= '0;
         o_operand <= '0;
         o_wrPc    <= 1'b0;
         o_selA    <= '0;
         o_selB    <= 1'b0;
         o_wrAcc   <= 1'b0;
         o_op      <= '0;
         o_wrRam   <= 1'b0;
         o_rdRam   <= 1'b0;
         o_halted  <= 1'b0;
         o_illegal <= 1'b0;
      end else begin
         o_wrPc  <= 1'b0;
         o_selA  <= '0;
         o_selB  <= 1'b0;
         o_wrAcc <= 1'b0;
         o_op    <= '0;
         o_wrRam <= 1'b0;
         o_rdRam <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (i_start) begin
                  state <= ST_FETCH;
               end
            end
            ST_FETCH: begin
               state <= ST_EXEC;
            end
            ST_EXEC: begin
               ir        <= i_instruction;
               o_operand <= cur_operand;
               if (!dec_legal || dec_halt) begin
                  state     <= ST_HALT;
                  o_halted  <= 1'b1;
                  o_illegal <= !dec_legal;
               end else if (rd_defer) begin
                  o_rdRam  <= 1'b1;
                  wait_cnt <= NB_WAIT'(RAM_RD_LAT);
                  state    <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               wait_cnt <= wait_cnt - NB_WAIT'(1);
            end
            ST_HALT: begin
               state <= ST_HALT;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase

         // Completion overrides the per-state choice: one pulse set, PC advance, count, next fetch or idle
         if (do_retire) begin
            o_wrPc  <= 1'b1;
            o_wrAcc <= dec_wr_acc;
            o_wrRam <= dec_wr_ram;
            o_rdRam <= dec_rd_ram && (RAM_RD_LAT == 0);
            o_selA  <= dec_sel_a;
            o_selB  <= dec_sel_b;
            o_op    <= dec_alu_op;
            o_pc    <= pc_next;
            count   <= count_next;
            state   <= i_step ? ST_IDLE : ST_FETCH;
         end
      end
   end

endmodule

// File: tb/tb_bip_control_unit.sv
// tb/tb_bip_control_unit.sv - scoreboard bench for bip_control_unit with an instruction-level reference model
module tb_bip_control_unit;

   localparam int LAT = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        step = 1'b0;
   logic [15:0] instr = '0;
   logic [10:0] pc;
   logic [10:0] operand;
   logic        wr_pc;
   logic [1:0]  sel_a;
   logic        sel_b;
   logic        wr_acc;
   logic [4:0]  op;
   logic        wr_ram;
   logic        rd_ram;
   logic        halted;
   logic        illegal;
   logic [15:0] count;

   always #5 clk = ~clk;

   bip_control_unit #(.RAM_RD_LAT(LAT)) dut (
      .i_clock       (clk),
      .i_reset       (rst_n),
      .i_start       (start),
      .i_step        (step),
      .i_instruction (instr),
      .o_pc          (pc),
      .o_operand     (operand),
      .o_wrPc        (wr_pc),
      .o_selA        (sel_a),
      .o_selB        (sel_b),
      .o_wrAcc       (wr_acc),
      .o_op          (op),
      .o_wrRam       (wr_ram),
      .o_rdRam       (rd_ram),
      .o_halted      (halted),
      .o_illegal     (illegal),
      .o_instr_count (count)
   );

   logic [15:0] pmem [0:2047];
   always @(posedge clk) instr <= pmem[pc];

   typedef struct {
      bit halt; bit ill; int cyc; int pc; int operand; int wr_acc; int wr_ram;
      int sel_a; int sel_b; int op; int count; int rd_cyc;
   } exp_t;

   exp_t expq[$];
   int   compared = 0;
   int   mismatched = 0;
   int   cyc = 0;
   int   start_c = 0;
   int   last_rd = -1;
   bit   prev_halted = 1'b0;
   int   m_pc = 0;
   int   m_count = 0;
   bit   m_halted = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void check(input string name, input int act, input int exp_v);
      compared++;
      if (act != exp_v) begin
         mismatched++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
      end
   endfunction

   // Instruction-level reference: walks program memory, stamps each event with its cycle from the start sample
   task automatic model_run(input bit stp);
      int t, opc, opd, n;
      logic [15:0] w;
      bit rd;
      exp_t e;
      if (m_halted) return;
      t = 1;
      n = 0;
      forever begin
         w   = pmem[m_pc];
         opc = int'(w[15:11]);
         opd = int'(w[10:0]);
         e   = '{default:0};
         if (opc == 0 || opc > 8) begin
            e.halt = 1; e.ill = (opc != 0); e.cyc = t + 2; e.pc = m_pc; e.count = m_count;
            expq.push_back(e);
            m_halted = 1;
            return;
         end
         rd = (opc == 2 || opc == 4 || opc == 6);
         t  = t + (rd ? 2 + LAT : 2);
         e.cyc = t; e.operand = opd; e.rd_cyc = rd ? t - LAT : -1;
         case (opc)
            1:       e.wr_ram = 1;
            2:       e.wr_acc = 1;
            3:       begin e.wr_acc = 1; e.sel_a = 1; end
            4, 6:    begin e.wr_acc = 1; e.sel_a = 2; e.op = opc; end
            5, 7:    begin e.wr_acc = 1; e.sel_a = 2; e.sel_b = 1; e.op = opc; end
            default: ;
         endcase
         m_pc = (opc == 8) ? opd : (m_pc + 1) % 2048;
         if (m_count < 65535) m_count++;
         e.pc = m_pc; e.count = m_count;
         expq.push_back(e);
         n++;
         if (stp || n > 500) return;
      end
   endtask

   // Monitor: samples after each edge, checks control hygiene and pops the scoreboard on retire/halt
   initial begin
      exp_t e;
      int rel;
      forever begin
         @(posedge clk); #1;
         if (!rst_n) begin
            prev_halted = 1'b0;
            last_rd = -1;
         end else begin
            rel = cyc - start_c + 1;
            compared++;
            if ((!wr_acc && (sel_a != 0 || sel_b || op != 0)) || ((wr_acc || wr_ram) && !wr_pc) ||
                (halted && (wr_pc || wr_acc || wr_ram || rd_ram))) begin
               mismatched++;
               $display("FAIL pulse_hygiene: wr_pc=%0d wr_acc=%0d wr_ram=%0d rd_ram=%0d sel_a=%0d sel_b=%0d op=%0d halted=%0d, expected clean controls",
                        wr_pc, wr_acc, wr_ram, rd_ram, sel_a, sel_b, op, halted);
            end
            if (rd_ram) last_rd = rel;
            if (wr_pc) begin
               if (expq.size() == 0) begin
                  compared++; mismatched++;
                  $display("FAIL unexpected_retire: pc=%0d at cycle %0d, expected no retirement", pc, rel);
               end else begin
                  e = expq.pop_front();
                  check("retire_kind", 0, int'(e.halt));
                  check("retire_cycle", rel, e.cyc);
                  check("retire_pc", int'(pc), e.pc);
                  check("retire_operand", int'(operand), e.operand);
                  check("retire_wr_acc", int'(wr_acc), e.wr_acc);
                  check("retire_wr_ram", int'(wr_ram), e.wr_ram);
                  check("retire_sel_a", int'(sel_a), e.sel_a);
                  check("retire_sel_b", int'(sel_b), e.sel_b);
                  check("retire_op", int'(op), e.op);
                  check("retire_count", int'(count), e.count);
                  check("retire_rd_cycle", last_rd, e.rd_cyc);
               end
               last_rd = -1;
            end
            if (halted && !prev_halted) begin
               if (expq.size() == 0) begin
                  compared++; mismatched++;
                  $display("FAIL unexpected_halt: pc=%0d at cycle %0d, expected no halt", pc, rel);
               end else begin
                  e = expq.pop_front();
                  check("halt_kind", 1, int'(e.halt));
                  check("halt_cycle", rel, e.cyc);
                  check("halt_illegal", int'(illegal), int'(e.ill));
                  check("halt_pc", int'(pc), e.pc);
                  check("halt_count", int'(count), e.count);
               end
            end
            prev_halted = halted;
         end
      end
   end

   task automatic clear_mem();
      for (int i = 0; i < 2048; i++) pmem[i] = '0;
   endtask

   task automatic reset_assert(input string tag);
      rst_n = 1'b0;
      #1;
      check({tag, "_pc"}, int'(pc), 0);
      check({tag, "_count"}, int'(count), 0);
      check({tag, "_ctrl"}, int'({operand, wr_pc, sel_a, sel_b, wr_acc, op, wr_ram, rd_ram, halted, illegal}), 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_assert("reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      m_pc = 0; m_count = 0; m_halted = 1'b0;
      expq.delete();
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start_c = cyc;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic drain(input string name);
      int k;
      k = 0;
      while (expq.size() != 0 && k < 3000) begin
         @(posedge clk);
         k++;
      end
      compared++;
      if (expq.size() != 0) begin
         mismatched++;
         $display("FAIL %s_timeout: %0d events pending, expected 0", name, expq.size());
         expq.delete();
      end
      repeat (4) @(negedge clk);
   endtask

   task automatic run_prog(input string name);
      model_run(1'b0);
      pulse_start();
      drain(name);
   endtask

   task automatic gen_prog();
      bit used [0:2047];
      logic [10:0] p, nxt, tgt;
      int n, opc;
      for (int i = 0; i < 2048; i++) begin
         pmem[i] = '0;
         used[i] = 1'b0;
      end
      p = '0;
      n = $urandom_range(6, 24);
      for (int i = 0; i < n; i++) begin
         used[p] = 1'b1;
         nxt = p + 11'd1;
         opc = $urandom_range(1, 8);
         if (used[nxt]) opc = 8;
         if (opc == 8) begin
            tgt = 11'($urandom);
            while (used[tgt]) tgt = 11'($urandom);
            pmem[p] = {5'd8, tgt};
            p = tgt;
         end else begin
            pmem[p] = {5'(opc), 11'($urandom)};
            p = nxt;
         end
      end
      if ($urandom_range(0, 1) == 0) pmem[p] = 16'd0;
      else                            pmem[p] = {5'($urandom_range(9, 31)), 11'($urandom)};
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

   initial begin
      int k;
      bit seen;
      clear_mem();
      do_reset();

      // LDI 5; ADDI 3; STO 7; HLT
      clear_mem();
      pmem[0] = {5'd3, 11'd5};
      pmem[1] = {5'd5, 11'd3};
      pmem[2] = {5'd1, 11'd7};
      pmem[3] = 16'd0;
      run_prog("basic");
      check("basic_pc", int'(pc), 3);
      check("basic_count", int'(count), 3);
      check("basic_halted", int'(halted), 1);
      pulse_start();
      pulse_start();
      repeat (6) @(negedge clk);
      check("halt_frozen_pc", int'(pc), 3);
      check("halt_frozen_count", int'(count), 3);
      check("halt_frozen_halted", int'(halted), 1);

      // RAM reads: LD 4; ADD 9; SUB 1; HLT
      do_reset();
      clear_mem();
      pmem[0] = {5'd2, 11'd4};
      pmem[1] = {5'd4, 11'd9};
      pmem[2] = {5'd6, 11'd1};
      run_prog("ram_read");

      // Jump to the top address, then wrap, single-stepped
      do_reset();
      clear_mem();
      pmem[0]     = {5'd8, 11'h7FF};
      pmem[11'h7FF] = {5'd3, 11'd9};
      step = 1'b1;
      for (int i = 0; i < 3; i++) begin
         model_run(1'b1);
         pulse_start();
         drain("step");
         check("step_pc", int'(pc), m_pc);
         check("step_count", int'(count), i + 1);
      end
      step = 1'b0;

      // Undefined opcode traps
      do_reset();
      clear_mem();
      pmem[0] = {5'd15, 11'd3};
      run_prog("illegal");
      pulse_start();
      repeat (6) @(negedge clk);
      check("illegal_flag", int'(illegal), 1);
      check("illegal_halted", int'(halted), 1);
      check("illegal_pc", int'(pc), 0);
      check("illegal_count", int'(count), 0);

      // Reset while an ADD waits on RAM, then a clean rerun
      do_reset();
      clear_mem();
      pmem[0] = {5'd4, 11'd4};
      pulse_start();
      k = 0;
      seen = 1'b0;
      while (!seen && k < 20) begin
         @(posedge clk); #1;
         seen = rd_ram;
         k++;
      end
      check("midwait_rd_seen", int'(seen), 1);
      #2;
      reset_assert("midwait");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      m_pc = 0; m_count = 0; m_halted = 1'b0;
      repeat (10) @(negedge clk);
      check("midwait_pc", int'(pc), 0);
      check("midwait_count", int'(count), 0);
      run_prog("restart");

      // Random programs, some continuous and some single-stepped
      for (int r = 0; r < 8; r++) begin
         do_reset();
         gen_prog();
         if (r % 3 == 2) begin
            step = 1'b1;
            k = 0;
            while (!m_halted && k < 100) begin
               model_run(1'b1);
               pulse_start();
               drain("rand_step");
               k++;
            end
            step = 1'b0;
         end else begin
            run_prog("rand");
         end
         check("rand_halted", int'(halted), 1);
         check("rand_pc", int'(pc), m_pc);
         check("rand_count", int'(count), m_count);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
